// File: rtl/controle_multiciclo_pkg.sv
// Shared encodings for the multicycle MIPS control unit: states, opcodes, functs,
// ALU codes, mux selects and the Moore output decode.
package controle_multiciclo_pkg;

  localparam int unsigned STATE_W  = 4;
  localparam int unsigned OP_W     = 6;
  localparam int unsigned FUNCT_W  = 6;
  localparam int unsigned ALU_OP_W = 4;
  localparam int unsigned CNT_W    = 4;

  typedef enum logic [STATE_W-1:0] {
    S_INIT      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXEC_R    = 4'd7,
    S_R_WB      = 4'd8,
    S_EXEC_I    = 4'd9,
    S_I_WB      = 4'd10,
    S_BRANCH    = 4'd11,
    S_JUMP      = 4'd12
  } state_e;

  localparam logic [OP_W-1:0] OP_R    = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW   = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW   = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ  = 6'b000100;
  localparam logic [OP_W-1:0] OP_J    = 6'b000010;
  localparam logic [OP_W-1:0] OP_ADDI = 6'b001000;
`ifdef MIPS_BNE_EN
  localparam logic [OP_W-1:0] OP_BNE  = 6'b000101;
`endif

  localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
  localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
  localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
  localparam logic [FUNCT_W-1:0] FN_OR  = 6'b100101;
  localparam logic [FUNCT_W-1:0] FN_NOR = 6'b100111;
  localparam logic [FUNCT_W-1:0] FN_SLT = 6'b101010;

  localparam logic [ALU_OP_W-1:0] ALU_AND = 4'b0000;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [ALU_OP_W-1:0] ALU_SLT = 4'b0111;
  localparam logic [ALU_OP_W-1:0] ALU_NOR = 4'b1100;

  localparam logic [1:0] SRC_B_REG    = 2'b00;
  localparam logic [1:0] SRC_B_FOUR   = 2'b01;
  localparam logic [1:0] SRC_B_IMM    = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  typedef struct packed {
    logic [ALU_OP_W-1:0] alu_op;
    logic                alu_src_a;
    logic [1:0]          alu_src_b;
    logic [1:0]          pc_source;
    logic                pc_write;
    logic                i_or_d;
    logic                mem_read;
    logic                mem_write;
    logic                ir_write;
    logic                reg_dst;
    logic                mem_to_reg;
    logic                reg_write;
  } ctrl_t;

  // Moore output decode; last marks the final cycle of a held state.
  function automatic ctrl_t moore_ctrl(input state_e s, input logic last,
                                       input logic [ALU_OP_W-1:0] alu_r);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_op    = ALU_ADD;
        c.alu_src_b = SRC_B_FOUR;
        c.pc_source = PC_SRC_ALU;
        c.ir_write  = last;
        c.pc_write  = last;
      end
      S_DECODE: begin
        c.alu_op    = ALU_ADD;
        c.alu_src_b = SRC_B_IMM_SH;
      end
      S_MEM_ADDR, S_EXEC_I: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRC_B_IMM;
        c.alu_op    = ALU_ADD;
      end
      S_MEM_READ: begin
        c.i_or_d   = 1'b1;
        c.mem_read = 1'b1;
      end
      S_MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        c.i_or_d    = 1'b1;
        c.mem_write = 1'b1;
      end
      S_EXEC_R: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRC_B_REG;
        c.alu_op    = alu_r;
      end
      S_R_WB: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
      end
      S_I_WB: c.reg_write = 1'b1;
      S_BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRC_B_REG;
        c.alu_op    = ALU_SUB;
        c.pc_source = PC_SRC_ALUOUT;
      end
      S_JUMP: begin
        c.pc_source = PC_SRC_JUMP;
        c.pc_write  = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/controle_multiciclo_ula.sv
// R-type funct decode: ALU operation plus a flag for supported functs.
module controle_ula
  import controle_multiciclo_pkg::*;
(
  input  logic [FUNCT_W-1:0]  funct_i,
  output logic [ALU_OP_W-1:0] alu_op_o,
  output logic                valid_o
);

  always_comb begin
    alu_op_o = ALU_ADD;
    valid_o  = 1'b1;
    case (funct_i)
      FN_ADD:  alu_op_o = ALU_ADD;
      FN_SUB:  alu_op_o = ALU_SUB;
      FN_AND:  alu_op_o = ALU_AND;
      FN_OR:   alu_op_o = ALU_OR;
      FN_NOR:  alu_op_o = ALU_NOR;
      FN_SLT:  alu_op_o = ALU_SLT;
      default: valid_o  = 1'b0;
    endcase
  end

endmodule

// File: rtl/controle_multiciclo.sv
// Multicycle MIPS control unit (R-type, lw, sw, beq, j, addi).
// Define MIPS_BNE_EN to also accept bne (opcode 000101).
module controle_multiciclo
  import controle_multiciclo_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [OP_W-1:0]     opcode,
  input  logic [FUNCT_W-1:0]  funct,
  input  logic                zero,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          pc_source,
  output logic                pc_write,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                illegal,
  output logic [STATE_W-1:0]  estado
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ALU_OP_W-1:0] alu_r_q, alu_r_d;
  logic                is_sw_q, is_sw_d;
  logic                bne_q, bne_d;
  ctrl_t               ctrl_q;
  logic [ALU_OP_W-1:0] ula_op;
  logic                ula_valid;
  logic                wait_done;
  logic                decode_bad;
  logic                branch_take;

  controle_ula u_ula (
    .funct_i  (funct),
    .alu_op_o (ula_op),
    .valid_o  (ula_valid)
  );

  assign wait_done = (cnt_q == CNT_W'(MEM_WAIT));

  // Next state, decoded-instruction registers and wait counter.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    alu_r_d    = alu_r_q;
    is_sw_d    = is_sw_q;
    bne_d      = bne_q;
    decode_bad = 1'b0;
    case (state_q)
      S_INIT:  state_d = S_FETCH;
      S_FETCH: if (wait_done) state_d = S_DECODE;
      S_DECODE: begin
        state_d = S_FETCH;
        alu_r_d = ula_op;
        is_sw_d = (opcode == OP_SW);
        bne_d   = 1'b0;
        case (opcode)
          OP_R: begin
            if (ula_valid) state_d = S_EXEC_R;
            else           decode_bad = 1'b1;
          end
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_ADDI:      state_d = S_EXEC_I;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
`ifdef MIPS_BNE_EN
          OP_BNE: begin
            state_d = S_BRANCH;
            bne_d   = 1'b1;
          end
`endif
          default:      decode_bad = 1'b1;
        endcase
      end
      S_MEM_ADDR:  state_d = is_sw_q ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (wait_done) state_d = S_MEM_WB;
      S_MEM_WRITE: if (wait_done) state_d = S_FETCH;
      S_EXEC_R:    state_d = S_R_WB;
      S_EXEC_I:    state_d = S_I_WB;
      S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      default:     state_d = S_INIT;
    endcase
    if (state_d != state_q) cnt_d = '0;
    else if (!wait_done)    cnt_d = cnt_q + CNT_W'(1);
  end

  // Outputs are decoded from the next state so they appear registered with it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      alu_r_q <= '0;
      is_sw_q <= 1'b0;
      bne_q   <= 1'b0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      alu_r_q <= alu_r_d;
      is_sw_q <= is_sw_d;
      bne_q   <= bne_d;
      ctrl_q  <= moore_ctrl(state_d, cnt_d == CNT_W'(MEM_WAIT), alu_r_d);
    end
  end

`ifdef MIPS_BNE_EN
  assign branch_take = (state_q == S_BRANCH) && (zero ^ bne_q);
`else
  assign branch_take = (state_q == S_BRANCH) && zero && !bne_q;
`endif

  assign alu_op     = ctrl_q.alu_op;
  assign alu_src_a  = ctrl_q.alu_src_a;
  assign alu_src_b  = ctrl_q.alu_src_b;
  assign pc_source  = ctrl_q.pc_source;
  assign pc_write   = ctrl_q.pc_write | branch_take;
  assign i_or_d     = ctrl_q.i_or_d;
  assign mem_read   = ctrl_q.mem_read;
  assign mem_write  = ctrl_q.mem_write;
  assign ir_write   = ctrl_q.ir_write;
  assign reg_dst    = ctrl_q.reg_dst;
  assign mem_to_reg = ctrl_q.mem_to_reg;
  assign reg_write  = ctrl_q.reg_write;
  assign illegal    = (state_q == S_DECODE) && decode_bad;
  assign estado     = state_q;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Bench for controle_multiciclo: MEM_WAIT=0 and MEM_WAIT=2 instances driven by shared inputs.
module tb_controle_multiciclo;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [5:0] opcode, funct;
  logic       zero;

  always #5 clock = ~clock;

  logic [3:0] aop0, aop2, st0, st2;
  logic [1:0] srcb0, srcb2, pcs0, pcs2;
  logic srca0, pcw0, iod0, mr0, mw0, irw0, rdst0, m2r0, rw0, ill0;
  logic srca2, pcw2, iod2, mr2, mw2, irw2, rdst2, m2r2, rw2, ill2;

  controle_multiciclo #(.MEM_WAIT(0)) u0 (
    .clock(clock), .reset_n(reset_n), .opcode(opcode), .funct(funct), .zero(zero),
    .alu_op(aop0), .alu_src_a(srca0), .alu_src_b(srcb0), .pc_source(pcs0),
    .pc_write(pcw0), .i_or_d(iod0), .mem_read(mr0), .mem_write(mw0),
    .ir_write(irw0), .reg_dst(rdst0), .mem_to_reg(m2r0), .reg_write(rw0),
    .illegal(ill0), .estado(st0)
  );

  controle_multiciclo #(.MEM_WAIT(2)) u2 (
    .clock(clock), .reset_n(reset_n), .opcode(opcode), .funct(funct), .zero(zero),
    .alu_op(aop2), .alu_src_a(srca2), .alu_src_b(srcb2), .pc_source(pcs2),
    .pc_write(pcw2), .i_or_d(iod2), .mem_read(mr2), .mem_write(mw2),
    .ir_write(irw2), .reg_dst(rdst2), .mem_to_reg(m2r2), .reg_write(rw2),
    .illegal(ill2), .estado(st2)
  );

  logic [21:0] act0, act2;
  assign act0 = {st0, aop0, srca0, srcb0, pcs0, pcw0, iod0, mr0, mw0, irw0, rdst0, m2r0, rw0, ill0};
  assign act2 = {st2, aop2, srca2, srcb2, pcs2, pcw2, iod2, mr2, mw2, irw2, rdst2, m2r2, rw2, ill2};

  // flag order: pc_write i_or_d mem_read mem_write ir_write reg_dst mem_to_reg reg_write illegal
  localparam logic [8:0] F_NONE = 9'b000000000;
  localparam logic [8:0] F_FL   = 9'b101010000;
  localparam logic [8:0] F_FW   = 9'b001000000;
  localparam logic [8:0] F_MR   = 9'b011000000;
  localparam logic [8:0] F_MW   = 9'b010100000;
  localparam logic [8:0] F_MWB  = 9'b000000110;
  localparam logic [8:0] F_RWB  = 9'b000001010;
  localparam logic [8:0] F_IWB  = 9'b000000010;
  localparam logic [8:0] F_PCW  = 9'b100000000;
  localparam logic [8:0] F_ILL  = 9'b000000001;

  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, J = 6'b000010, ADDI = 6'b001000, BNE = 6'b000101;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic [21:0] exp;
  } vec_t;

  typedef struct {
    int          dut;
    int          row;
    logic [21:0] exp;
  } sb_t;

  vec_t prog0[$];
  vec_t prog2[$];
  sb_t  sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [21:0] ex(input logic [3:0] st, input logic [3:0] aop, input logic a,
                                     input logic [1:0] b, input logic [1:0] ps, input logic [8:0] fl);
    return {st, aop, a, b, ps, fl};
  endfunction

  function automatic logic [21:0] e_init();   return ex(4'd0, 4'b0000, 1'b0, 2'b00, 2'b00, F_NONE); endfunction
  function automatic logic [21:0] e_fetch(input logic last);
    return ex(4'd1, 4'b0010, 1'b0, 2'b01, 2'b00, last ? F_FL : F_FW);
  endfunction
  function automatic logic [21:0] e_dec(input logic ill);
    return ex(4'd2, 4'b0010, 1'b0, 2'b11, 2'b00, ill ? F_ILL : F_NONE);
  endfunction
  function automatic logic [21:0] e_madr(); return ex(4'd3, 4'b0010, 1'b1, 2'b10, 2'b00, F_NONE); endfunction
  function automatic logic [21:0] e_branch(input logic take);
    return ex(4'd11, 4'b0110, 1'b1, 2'b00, 2'b01, take ? F_PCW : F_NONE);
  endfunction

  function automatic void r0(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic [21:0] e);
    vec_t v;
    v.op = op; v.fn = fn; v.z = z; v.exp = e;
    prog0.push_back(v);
  endfunction

  function automatic void r2(input logic [5:0] op, input logic [21:0] e);
    vec_t v;
    v.op = op; v.fn = 6'b000000; v.z = 1'b0; v.exp = e;
    prog2.push_back(v);
  endfunction

  // MEM_WAIT=0 R-type: FETCH, DECODE, EXEC_R, R_WB
  function automatic void rtype(input logic [5:0] fn, input logic [3:0] aop);
    r0(R, fn, 1'b0, e_fetch(1'b1));
    r0(R, fn, 1'b0, e_dec(1'b0));
    r0(R, fn, 1'b0, ex(4'd7, aop, 1'b1, 2'b00, 2'b00, F_NONE));
    r0(R, fn, 1'b0, ex(4'd8, 4'b0000, 1'b0, 2'b00, 2'b00, F_RWB));
  endfunction

  task automatic check_one();
    sb_t e;
    logic [21:0] act;
    e = sb_q.pop_front();
    act = (e.dut == 2) ? act2 : act0;
    n_cmp++;
    if (act !== e.exp) begin
      n_bad++;
      $display("FAIL u%0d row %0d: got %b want %b", e.dut, e.row, act, e.exp);
    end
  endtask

  task automatic expect_now(input int dut, input int row, input logic [21:0] e);
    sb_t s;
    s.dut = dut; s.row = row; s.exp = e;
    sb_q.push_back(s);
  endtask

  task automatic apply(input int dut, input int row, input vec_t v);
    opcode = v.op; funct = v.fn; zero = v.z;
    expect_now(dut, row, v.exp);
    @(negedge clock);
    check_one();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input int row);
    reset_n = 1'b0;
    opcode = 6'b0; funct = 6'b0; zero = 1'b0;
    @(negedge clock);
    expect_now(0, row, e_init());
    expect_now(2, row, e_init());
    check_one();
    check_one();
    @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    opcode = 6'b0; funct = 6'b0; zero = 1'b0;

    // MEM_WAIT=0 program
    r0(R, 6'b100000, 1'b0, e_init());
    rtype(6'b100000, 4'b0010);
    rtype(6'b100010, 4'b0110);
    rtype(6'b100100, 4'b0000);
    rtype(6'b100101, 4'b0001);
    rtype(6'b100111, 4'b1100);
    rtype(6'b101010, 4'b0111);
    r0(ADDI, 6'b0, 1'b0, e_fetch(1'b1));
    r0(ADDI, 6'b0, 1'b0, e_dec(1'b0));
    r0(ADDI, 6'b0, 1'b0, ex(4'd9, 4'b0010, 1'b1, 2'b10, 2'b00, F_NONE));
    r0(ADDI, 6'b0, 1'b0, ex(4'd10, 4'b0000, 1'b0, 2'b00, 2'b00, F_IWB));
    r0(LW, 6'b0, 1'b0, e_fetch(1'b1));
    r0(LW, 6'b0, 1'b0, e_dec(1'b0));
    r0(LW, 6'b0, 1'b0, e_madr());
    r0(LW, 6'b0, 1'b0, ex(4'd4, 4'b0000, 1'b0, 2'b00, 2'b00, F_MR));
    r0(LW, 6'b0, 1'b0, ex(4'd5, 4'b0000, 1'b0, 2'b00, 2'b00, F_MWB));
    r0(SW, 6'b0, 1'b0, e_fetch(1'b1));
    r0(SW, 6'b0, 1'b0, e_dec(1'b0));
    r0(SW, 6'b0, 1'b0, e_madr());
    r0(SW, 6'b0, 1'b0, ex(4'd6, 4'b0000, 1'b0, 2'b00, 2'b00, F_MW));
    r0(BEQ, 6'b0, 1'b1, e_fetch(1'b1));
    r0(BEQ, 6'b0, 1'b1, e_dec(1'b0));
    r0(BEQ, 6'b0, 1'b1, e_branch(1'b1));
    r0(BEQ, 6'b0, 1'b0, e_fetch(1'b1));
    r0(BEQ, 6'b0, 1'b0, e_dec(1'b0));
    r0(BEQ, 6'b0, 1'b0, e_branch(1'b0));
    r0(J, 6'b0, 1'b0, e_fetch(1'b1));
    r0(J, 6'b0, 1'b0, e_dec(1'b0));
    r0(J, 6'b0, 1'b0, ex(4'd12, 4'b0000, 1'b0, 2'b00, 2'b10, F_PCW));
    r0(6'b111111, 6'b0, 1'b0, e_fetch(1'b1));
    r0(6'b111111, 6'b0, 1'b0, e_dec(1'b1));
    r0(R, 6'b000000, 1'b0, e_fetch(1'b1));
    r0(R, 6'b000000, 1'b0, e_dec(1'b1));
    r0(BNE, 6'b0, 1'b0, e_fetch(1'b1));
`ifdef MIPS_BNE_EN
    r0(BNE, 6'b0, 1'b0, e_dec(1'b0));
    r0(BNE, 6'b0, 1'b0, e_branch(1'b1));
    r0(BNE, 6'b0, 1'b1, e_fetch(1'b1));
    r0(BNE, 6'b0, 1'b1, e_dec(1'b0));
    r0(BNE, 6'b0, 1'b1, e_branch(1'b0));
`else
    r0(BNE, 6'b0, 1'b0, e_dec(1'b1));
`endif
    r0(R, 6'b100000, 1'b0, e_fetch(1'b1));

    // MEM_WAIT=2 program: lw (9 cycles) then sw up to the first MEM_WRITE cycle
    r2(LW, e_init());
    r2(LW, e_fetch(1'b0));
    r2(LW, e_fetch(1'b0));
    r2(LW, e_fetch(1'b1));
    r2(LW, e_dec(1'b0));
    r2(LW, e_madr());
    r2(LW, ex(4'd4, 4'b0000, 1'b0, 2'b00, 2'b00, F_MR));
    r2(LW, ex(4'd4, 4'b0000, 1'b0, 2'b00, 2'b00, F_MR));
    r2(LW, ex(4'd4, 4'b0000, 1'b0, 2'b00, 2'b00, F_MR));
    r2(LW, ex(4'd5, 4'b0000, 1'b0, 2'b00, 2'b00, F_MWB));
    r2(SW, e_fetch(1'b0));
    r2(SW, e_fetch(1'b0));
    r2(SW, e_fetch(1'b1));
    r2(SW, e_dec(1'b0));
    r2(SW, e_madr());
    r2(SW, ex(4'd6, 4'b0000, 1'b0, 2'b00, 2'b00, F_MW));

    do_reset(1000);
    foreach (prog0[i]) apply(0, i, prog0[i]);

    do_reset(2000);
    foreach (prog2[i]) apply(2, 100 + i, prog2[i]);

    // Second MEM_WRITE cycle: reset mid-cycle must clear everything at once
    #2 reset_n = 1'b0;
    #1;
    expect_now(2, 300, e_init());
    check_one();
    @(posedge clock);
    #1 reset_n = 1'b1;
    begin
      vec_t v;
      v.op = SW; v.fn = 6'b0; v.z = 1'b0;
      v.exp = e_init();
      apply(2, 301, v);
      v.exp = e_fetch(1'b0);
      apply(2, 302, v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
